// File: rtl/burst_error_scheduler.sv
// burst_error_scheduler
// ---------------------------------------------------------------------------
// Single-stage valid/ready pipe for 64-bit words. It can XOR a short burst
// error into selected words. A burst goes into one word out of every
// cfg_period accepted words. An LFSR supplies the burst position, the burst
// length and the interior bit pattern.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   cfg_load         one-cycle pulse: load the LFSR seed and clear the period
//                    counter. No word is accepted in that cycle.
//   cfg_seed[15:0]   LFSR seed. A seed of 0 is replaced by 16'hACE1.
//   cfg_period[7:0]  inject one burst per cfg_period words (0 = pass-through)
//   in_valid/in_data/in_ready     upstream handshake
//   out_valid/out_data/out_ready  downstream handshake
//   out_err          the current output word carries a burst
//   out_burst_start  lowest flipped bit index (0 when out_err=0)
//   out_burst_len    burst span in bits, 2..7 (0 when out_err=0)
//   err_count        number of injected words accepted, saturating at FFFF
// ---------------------------------------------------------------------------
module burst_error_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_load,
  input  logic [15:0] cfg_seed,
  input  logic [7:0]  cfg_period,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        out_err,
  output logic [5:0]  out_burst_start,
  output logic [2:0]  out_burst_len,
  output logic [15:0] err_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  state_t      state_reg, state_next;
  logic [15:0] lfsr_reg;
  logic [7:0]  pcnt_reg;
  logic [63:0] out_data_reg;
  logic        out_err_reg;
  logic [5:0]  out_start_reg;
  logic [2:0]  out_len_reg;
  logic [15:0] err_count_reg;

  logic        accept;
  logic        inject;
  logic [15:0] lfsr_next;
  logic [2:0]  len_mod;
  logic [2:0]  burst_len;
  logic [2:0]  last_idx;
  logic [6:0]  burst_end;
  logic [5:0]  burst_start;
  logic [6:0]  burst_pat;
  logic [63:0] burst_mask;

  // in_ready is held low during reset. Without that term it would be high,
  // because out_valid is already cleared while rst_n is low.
  assign out_valid = (state_reg == S_FULL);
  assign in_ready  = rst_n && !cfg_load && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // FSM: state register plus next-state logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_EMPTY: if (accept) state_next = S_FULL;
      S_FULL:  if (out_ready && !accept) state_next = S_EMPTY;
      default: state_next = S_EMPTY;
    endcase
  end

  // Burst fields come from the LFSR value before it advances.
  assign lfsr_next = {lfsr_reg[14:0],
                      lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign len_mod   = (lfsr_reg[2:0] >= 3'd6) ? (lfsr_reg[2:0] - 3'd6) : lfsr_reg[2:0];
  assign burst_len = len_mod + 3'd2;
  assign last_idx  = burst_len - 3'd1;
  assign burst_end = {1'b0, lfsr_reg[8:3]} + {4'b0, burst_len};
  // Move the burst down so that it never wraps past bit 63.
  assign burst_start = (burst_end > 7'd64) ? 6'(7'd64 - {4'b0, burst_len})
                                           : lfsr_reg[8:3];

  // Burst pattern relative to the start bit. Both end bits are always set.
  // Interior bit k is taken from lfsr bit 9+k.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_pat
      if (gi == 0) begin : g_first
        assign burst_pat[gi] = 1'b1;
      end else begin : g_rest
        assign burst_pat[gi] = (3'(gi) == last_idx) ||
                               ((3'(gi) < last_idx) && lfsr_reg[9+gi]);
      end
    end
  endgenerate

  assign burst_mask = {57'b0, burst_pat} << burst_start;
  assign inject     = (cfg_period != 8'd0) && (pcnt_reg == cfg_period - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg      <= LFSR_DEFAULT;
      pcnt_reg      <= 8'd0;
      out_data_reg  <= 64'd0;
      out_err_reg   <= 1'b0;
      out_start_reg <= 6'd0;
      out_len_reg   <= 3'd0;
      err_count_reg <= 16'd0;
    end else begin
      if (cfg_load) begin
        lfsr_reg <= (cfg_seed == 16'd0) ? LFSR_DEFAULT : cfg_seed;
        pcnt_reg <= 8'd0;
      end else if (accept) begin
        // accept cannot be high while cfg_load is high, because in_ready
        // is gated by cfg_load.
        lfsr_reg <= lfsr_next;
        if (inject || (cfg_period == 8'd0)) pcnt_reg <= 8'd0;
        else                                pcnt_reg <= pcnt_reg + 8'd1;
        out_data_reg  <= in_data ^ (inject ? burst_mask : 64'd0);
        out_err_reg   <= inject;
        out_start_reg <= inject ? burst_start : 6'd0;
        out_len_reg   <= inject ? burst_len : 3'd0;
        if (inject && (err_count_reg != 16'hFFFF))
          err_count_reg <= err_count_reg + 16'd1;
      end
    end
  end

  assign out_data        = out_data_reg;
  assign out_err         = out_err_reg;
  assign out_burst_start = out_start_reg;
  assign out_burst_len   = out_len_reg;
  assign err_count       = err_count_reg;

endmodule

// File: tb/tb_burst_error_scheduler.sv
// tb_burst_error_scheduler
// Directed test of burst_error_scheduler. The inputs are driven 1 ns after
// each rising edge. The outputs are sampled 1 ns after the edge as well.
module tb_burst_error_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_load;
  logic [15:0] cfg_seed;
  logic [7:0]  cfg_period;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        out_err;
  logic [5:0]  out_burst_start;
  logic [2:0]  out_burst_len;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  burst_error_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_load        (cfg_load),
    .cfg_seed        (cfg_seed),
    .cfg_period      (cfg_period),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .out_err         (out_err),
    .out_burst_start (out_burst_start),
    .out_burst_len   (out_burst_len),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-20s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    logic [63:0] word;
    rst_n = 1'b0; cfg_load = 1'b0; cfg_seed = 16'd0; cfg_period = 8'd0;
    in_valid = 1'b1; in_data = 64'd0; out_ready = 1'b1;

    // Reset state. in_valid is held high to show that in_ready stays low.
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 0);
    step(); step();
    rst_n = 1'b1; in_valid = 1'b0;

    // seed 1, period 1: two zero words give 0x5 and then 0x9
    cfg_load = 1'b1; cfg_seed = 16'h0001; cfg_period = 8'd1;
    in_valid = 1'b1; in_data = 64'd0;
    #1 chk("load_in_ready", in_ready, 0);
    step();
    chk("load_no_accept", out_valid, 0);
    cfg_load = 1'b0;
    step();
    chk("s1_w0_data", out_data, 64'h5);
    chk("s1_w0_err", out_err, 1);
    chk("s1_w0_start", out_burst_start, 0);
    chk("s1_w0_len", out_burst_len, 3);
    chk("s1_w0_cnt", err_count, 1);
    step();
    chk("s1_w1_data", out_data, 64'h9);
    chk("s1_w1_len", out_burst_len, 4);
    chk("s1_w1_cnt", err_count, 2);
    in_valid = 1'b0;
    step();
    chk("s1_drain", out_valid, 0);

    // seed 01FD: the start position is clamped to 57 and the length is 7
    cfg_load = 1'b1; cfg_seed = 16'h01FD;
    step();
    cfg_load = 1'b0; in_valid = 1'b1; in_data = 64'd0;
    step();
    chk("clamp_data", out_data, 64'h8200_0000_0000_0000);
    chk("clamp_start", out_burst_start, 57);
    chk("clamp_len", out_burst_len, 7);
    in_valid = 1'b0;
    step();

    // period 0: pass-through
    cfg_period = 8'd0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      word = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      in_data = word;
      step();
      chk($sformatf("pt%0d_data", i), out_data, word);
      chk($sformatf("pt%0d_err", i), out_err, 0);
      chk($sformatf("pt%0d_len", i), out_burst_len, 0);
    end
    in_valid = 1'b0;
    step();
    chk("pt_err_count", err_count, 3);

    // period 3: only the 3rd, 6th and 9th words carry a burst
    cfg_period = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      word = 64'h1234_5678_0000_0000 | 64'(i);
      in_data = word;
      step();
      chk($sformatf("p3_w%0d_err", i), out_err, (i % 3 == 2) ? 1 : 0);
      if (i % 3 != 2) chk($sformatf("p3_w%0d_data", i), out_data, word);
    end
    in_valid = 1'b0;
    step();
    chk("p3_err_count", err_count, 6);

    // Backpressure: hold out_ready low for 5 cycles, then stream
    cfg_period = 8'd0; in_valid = 1'b1; in_data = 64'hAAAA_0000_0000_0001;
    step();
    out_ready = 1'b0; in_data = 64'hBBBB_0000_0000_0002;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
      step();
      chk($sformatf("stall%0d_valid", i), out_valid, 1);
      chk($sformatf("stall%0d_data", i), out_data, 64'hAAAA_0000_0000_0001);
    end
    out_ready = 1'b1;
    #1 chk("resume_in_ready", in_ready, 1);
    step();
    chk("stream_b_valid", out_valid, 1);
    chk("stream_b_data", out_data, 64'hBBBB_0000_0000_0002);
    in_data = 64'hCCCC_0000_0000_0003;
    step();
    chk("stream_c_valid", out_valid, 1);
    chk("stream_c_data", out_data, 64'hCCCC_0000_0000_0003);
    cfg_load = 1'b1; cfg_seed = 16'h0001; cfg_period = 8'd1;
    in_data = 64'hDDDD_0000_0000_0004;
    #1 chk("cfgload_in_ready", in_ready, 0);
    step();
    chk("cfgload_drained", out_valid, 0);
    cfg_load = 1'b0;

    // Saturation: 65528 more injections bring err_count from 6 to FFFE
    in_valid = 1'b1; in_data = 64'd0;
    repeat (65528) @(posedge clk);
    #1 chk("sat_fffe", err_count, 16'hFFFE);
    step();
    chk("sat_ffff", err_count, 16'hFFFF);
    step(); step();
    chk("sat_hold", err_count, 16'hFFFF);

    // Reset asserted while FULL drops the held word
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", err_count, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
